// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder and subtractor).
package bit_serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow into the next bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow of a single bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/bit_subtractor.sv
// Bit-serial subtractor: diff = A - B, one bit per clock, LSB first.
//
// state | meaning
// IDLE  | waiting for start; result and flags held
// SHIFT | one difference bit produced per clock, WIDTH clocks
// DONE  | single-cycle done pulse, result valid
module bit_subtractor
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             brw;
    logic [CNT_W-1:0] cnt;
    logic             d_bit;
    logic             bout_bit;
    logic             last_bit;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign last_bit = (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs derived from the state.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, serial datapath and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr       <= A;
                        b_sr       <= B;
                        brw        <= 1'b0;
                        cnt        <= '0;
                        diff       <= '0;
                        borrow_out <= 1'b0;
                        overflow   <= 1'b0;
                    end
                end
                SHIFT: begin
                    diff <= {d_bit, diff[WIDTH-1:1]};
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    brw  <= bout_bit;
                    cnt  <= cnt + 1'b1;
                    // On the last bit the shift-register LSBs hold the operand MSBs.
                    if (last_bit) begin
                        borrow_out <= bout_bit;
                        overflow   <= (a_sr[0] ^ b_sr[0]) & (d_bit ^ a_sr[0]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_subtractor.sv
// Directed self-checking bench for bit_subtractor (WIDTH = 8).
module tb_bit_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] diff;
    logic       borrow_out;
    logic       overflow;
    logic       busy;
    logic       done;

    int total  = 0;
    int passed = 0;

    bit_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .A          (A),
        .B          (B),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and wait (bounded) for done. lat counts edges from
    // the accepting edge inclusive, so done is expected at lat == 9.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output bit timed_out);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = ~a;
        B = 8'h5A;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        timed_out = !done;
    endtask

    task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp_diff, input logic exp_brw,
                            input logic exp_ovf);
        int lat;
        bit to;
        do_op(a, b, lat, to);
        total++;
        if (to || lat !== 9) $display("FAIL %s latency: got %0d (timeout=%0d) want 9", name, lat, to);
        else passed++;
        total++;
        if (diff !== exp_diff) $display("FAIL %s diff: got %0h want %0h", name, diff, exp_diff);
        else passed++;
        total++;
        if (borrow_out !== exp_brw) $display("FAIL %s borrow_out: got %0b want %0b", name, borrow_out, exp_brw);
        else passed++;
        total++;
        if (overflow !== exp_ovf) $display("FAIL %s overflow: got %0b want %0b", name, overflow, exp_ovf);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== exp_diff)
            $display("FAIL %s after-done: done=%0b busy=%0b diff=%0h want 0 0 %0h",
                     name, done, busy, diff, exp_diff);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        A = 8'h00;
        B = 8'h00;
        #12;
        total++;
        if ({diff, borrow_out, overflow, busy, done} !== 12'h000)
            $display("FAIL reset outputs: got diff=%0h brw=%0b ovf=%0b busy=%0b done=%0b want all 0",
                     diff, borrow_out, overflow, busy, done);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle after reset: busy=%0b done=%0b want 0 0", busy, done);
        else passed++;
    endtask

    task automatic test_arith();
        check_op("55-31",   8'd55,  8'd31,  8'd24,  1'b0, 1'b0);
        check_op("31-55",   8'd31,  8'd55,  8'hE8,  1'b1, 1'b0);
        check_op("7F-FF",   8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1);
        check_op("80-01",   8'h80,  8'h01,  8'h7F,  1'b0, 1'b1);
    endtask

    task automatic test_start_ignored();
        int lat;
        int ndone;
        @(negedge clk);
        A = 8'd55;
        B = 8'd31;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        ndone = 0;
        while (busy && lat < 40) begin
            if (lat == 3) begin
                A = 8'd0;
                B = 8'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                ndone++;
                total++;
                if (lat !== 9 || diff !== 8'd24)
                    $display("FAIL ignore-start result: lat=%0d diff=%0d want 9 24", lat, diff);
                else passed++;
            end
        end
        start = 1'b0;
        total++;
        if (ndone !== 1) $display("FAIL ignore-start done pulses: got %0d want 1", ndone);
        else passed++;
        total++;
        if (busy !== 1'b0 || diff !== 8'd24)
            $display("FAIL ignore-start idle: busy=%0b diff=%0d want 0 24", busy, diff);
        else passed++;
        // Immediate restart from IDLE on the edge after DONE.
        check_op("A5-A5", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        int ndone;
        @(negedge clk);
        A = 8'hFF;
        B = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || diff === 8'h00)
            $display("FAIL abort pre-reset: busy=%0b diff=%0h want busy 1, partial diff nonzero", busy, diff);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({diff, borrow_out, overflow, busy, done} !== 12'h000)
            $display("FAIL abort async clear: diff=%0h brw=%0b ovf=%0b busy=%0b done=%0b want all 0",
                     diff, borrow_out, overflow, busy, done);
        else passed++;
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        total++;
        if (ndone !== 0) $display("FAIL abort no activity: got %0d busy/done cycles want 0", ndone);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        // 200 - 100: as signed bytes this is -56 - 100 = -156, which overflows.
        check_op("200-100", 8'd200, 8'd100, 8'd100, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_start_ignored();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
